// File: rtl/stk_pipe_al_mp.sv
// stk_pipe_al_mp: banked free-pool pointer allocator.
//   Free pointers sit in one LIFO stack per bank, and each stack is a single-port SRAM.
//   An alloc in the ad stage returns a pointer in the lk stage. DEALLOC_N ports return pointers.
//   A returned pointer can bypass the stacks and go straight to a same-cycle alloc.
// Ports:
//   clk, arst_n        clock, async active-low reset
//   i_ad_alloc         alloc request
//   o_ad_busy_r        init in progress
//   o_ad_empty_r       free count is zero
//   o_ad_low_r         free count <= LOW_WM
//   o_lk_vld_r         lk-stage pointer valid
//   o_lk_ptr_w         lk-stage pointer {bank, line}
//   i_dealloc_vld/ptr  return ports; port k uses ptr bits [k*PTR_W +: PTR_W]
//   o_dealloc_rdy      per-port accept
//   o_free_cnt_r       free pointer count
//   o_err_r            sticky: [0] alloc underflow, [1] push to full bank

// One bank: a LIFO stack on a single-port SRAM.
// push_i and pop_i are never high together. Read data is registered.
module stk_pipe_al_mp_bank #(
  parameter int LINES  = 64,
  parameter int LINE_W = 6
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              push_i,
  input  logic [LINE_W-1:0] push_line_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              nempty_o,
  output logic [LINE_W-1:0] dout_o
);
  logic [LINE_W-1:0] mem [LINES];
  logic [LINE_W:0]   sp_q;
  logic [LINE_W-1:0] dout_q;
  logic [LINE_W-1:0] top_idx;

  // This only wraps when sp_q == LINES, and then index LINES-1 is the right entry.
  assign top_idx  = sp_q[LINE_W-1:0] - 1'b1;
  assign full_o   = sp_q[LINE_W];
  assign nempty_o = |sp_q;
  assign dout_o   = dout_q;

  always_ff @(posedge clk)
    if (push_i) mem[sp_q[LINE_W-1:0]] <= push_line_i;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sp_q   <= '0;
      dout_q <= '0;
    end else if (push_i) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop_i) begin
      sp_q   <= sp_q - 1'b1;
      dout_q <= mem[top_idx];
    end
  end
endmodule

module stk_pipe_al_mp #(
  parameter  int BANKS_N      = 4,
  parameter  int BANK_LINES_N = 64,
  parameter  int DEALLOC_N    = 2,
  parameter  int LOW_WM       = 4,
  localparam int BNK_W        = $clog2(BANKS_N),
  localparam int LINE_W       = $clog2(BANK_LINES_N),
  localparam int PTR_W        = BNK_W + LINE_W,
  localparam int CNT_W        = $clog2(BANKS_N*BANK_LINES_N+1)
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       i_ad_alloc,
  output logic                       o_ad_busy_r,
  output logic                       o_ad_empty_r,
  output logic                       o_ad_low_r,
  output logic                       o_lk_vld_r,
  output logic [PTR_W-1:0]           o_lk_ptr_w,
  input  logic [DEALLOC_N-1:0]       i_dealloc_vld,
  input  logic [DEALLOC_N*PTR_W-1:0] i_dealloc_ptr,
  output logic [DEALLOC_N-1:0]       o_dealloc_rdy,
  output logic [CNT_W-1:0]           o_free_cnt_r,
  output logic [1:0]                 o_err_r
);
  typedef enum logic {ST_INIT, ST_RUN} st_e;

  st_e                             st_q;
  logic [LINE_W-1:0]               init_c_q;
  logic                            busy_q, empty_q, low_q;
  logic [CNT_W-1:0]                free_cnt_q, free_cnt_d;
  logic [1:0]                      err_q;
  logic [BNK_W-1:0]                rr_q;
  logic                            lk_vld_q, lk_byp_q;
  logic [PTR_W-1:0]                lk_byp_ptr_q;
  logic [BNK_W-1:0]                lk_bnk_q;

  logic                            run;
  logic [DEALLOC_N-1:0][BNK_W-1:0] d_bnk;
  logic [DEALLOC_N-1:0][LINE_W-1:0] d_line;
  logic [DEALLOC_N-1:0]            rdy, acc;
  logic                            any_acc, byp, pop_req, udf, ovf;
  int                              byp_idx;
  logic [PTR_W-1:0]                byp_ptr;
  logic [BANKS_N-1:0]              push_req, push_eff, pop_b, full, nempty;
  logic [BANKS_N-1:0][LINE_W-1:0]  push_line, bank_dout;
  logic [BNK_W-1:0]                gnt, idx;
  logic [CNT_W-1:0]                npush;

  assign run = (st_q == ST_RUN);

  for (genvar k = 0; k < DEALLOC_N; k++) begin : g_dp
    assign d_bnk[k]  = i_dealloc_ptr[k*PTR_W+LINE_W +: BNK_W];
    assign d_line[k] = i_dealloc_ptr[k*PTR_W +: LINE_W];
  end

  // A port is blocked by any lower-index valid port to the same bank.
  // A bank therefore gets at most one push per cycle.
  always_comb begin
    for (int k = 0; k < DEALLOC_N; k++) begin
      rdy[k] = run;
      for (int j = 0; j < k; j++)
        if (i_dealloc_vld[j] && d_bnk[j] == d_bnk[k]) rdy[k] = 1'b0;
    end
  end
  assign acc           = i_dealloc_vld & rdy;
  assign any_acc       = |acc;
  assign o_dealloc_rdy = rdy;

  // The lowest-index accepted return feeds an alloc in the same cycle.
  always_comb begin
    byp     = 1'b0;
    byp_idx = 0;
    byp_ptr = '0;
    for (int k = DEALLOC_N-1; k >= 0; k--)
      if (run && i_ad_alloc && acc[k]) begin
        byp     = 1'b1;
        byp_idx = k;
        byp_ptr = i_dealloc_ptr[k*PTR_W +: PTR_W];
      end
  end

  assign pop_req = run && i_ad_alloc && !any_acc && (free_cnt_q != '0);
  assign udf     = run && i_ad_alloc && !any_acc && (free_cnt_q == '0);

  // The round-robin search starts at rr_q.
  // A nonzero free count guarantees that some bank is non-empty.
  always_comb begin
    gnt = rr_q;
    idx = rr_q;
    for (int i = BANKS_N-1; i >= 0; i--) begin
      idx = rr_q + BNK_W'(i);
      if (nempty[idx]) gnt = idx;
    end
  end

  // Stack pushes per bank. During init every bank is fed the same line, counting down.
  always_comb begin
    for (int b = 0; b < BANKS_N; b++) begin
      push_req[b]  = !run;
      push_line[b] = LINE_W'(BANK_LINES_N-1) - init_c_q;
    end
    if (run)
      for (int k = 0; k < DEALLOC_N; k++)
        if (acc[k] && !(byp && k == byp_idx)) begin
          push_req[d_bnk[k]]  = 1'b1;
          push_line[d_bnk[k]] = d_line[k];
        end
  end

  assign push_eff = push_req & ~full;
  assign ovf      = |(push_req & full);
  assign pop_b    = pop_req ? (BANKS_N'(1) << gnt) : '0;

  always_comb begin
    npush = '0;
    for (int b = 0; b < BANKS_N; b++) npush = npush + CNT_W'(push_eff[b]);
  end
  assign free_cnt_d = free_cnt_q + npush - CNT_W'(pop_req);

  for (genvar b = 0; b < BANKS_N; b++) begin : g_bank
    stk_pipe_al_mp_bank #(.LINES(BANK_LINES_N), .LINE_W(LINE_W)) u_bank (
      .clk         (clk),
      .arst_n      (arst_n),
      .push_i      (push_eff[b]),
      .push_line_i (push_line[b]),
      .pop_i       (pop_b[b]),
      .full_o      (full[b]),
      .nempty_o    (nempty[b]),
      .dout_o      (bank_dout[b])
    );
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st_q         <= ST_INIT;
      init_c_q     <= '0;
      busy_q       <= 1'b1;
      empty_q      <= 1'b1;
      low_q        <= 1'b1;
      free_cnt_q   <= '0;
      err_q        <= '0;
      rr_q         <= '0;
      lk_vld_q     <= 1'b0;
      lk_byp_q     <= 1'b0;
      lk_byp_ptr_q <= '0;
      lk_bnk_q     <= '0;
    end else begin
      if (st_q == ST_INIT) begin
        init_c_q <= init_c_q + 1'b1;
        if (init_c_q == LINE_W'(BANK_LINES_N-1)) begin
          st_q   <= ST_RUN;
          busy_q <= 1'b0;
        end
      end
      free_cnt_q <= free_cnt_d;
      empty_q    <= (free_cnt_d == '0);
      low_q      <= (free_cnt_d <= CNT_W'(LOW_WM));
      err_q      <= err_q | {ovf, udf};
      lk_vld_q   <= byp | pop_req;
      if (byp) begin
        lk_byp_q     <= 1'b1;
        lk_byp_ptr_q <= byp_ptr;
      end else if (pop_req) begin
        lk_byp_q <= 1'b0;
        lk_bnk_q <= gnt;
        rr_q     <= gnt + 1'b1;
      end
    end
  end

  assign o_ad_busy_r  = busy_q;
  assign o_ad_empty_r = empty_q;
  assign o_ad_low_r   = low_q;
  assign o_free_cnt_r = free_cnt_q;
  assign o_err_r      = err_q;
  assign o_lk_vld_r   = lk_vld_q;
  // A popped pointer takes its line straight from the SRAM read data in the lk cycle.
  assign o_lk_ptr_w   = lk_byp_q ? lk_byp_ptr_q : {lk_bnk_q, bank_dout[lk_bnk_q]};
endmodule

// File: tb/tb_stk_pipe_al_mp.sv
module tb_stk_pipe_al_mp;
  logic       clk = 1'b0;
  logic       arst_n;
  logic       alloc;
  logic       busy, empty, low, lk_vld;
  logic [7:0] lk_ptr;
  logic [1:0] dvld;
  logic [15:0] dptr;
  logic [1:0] rdy;
  logic [8:0] free_cnt;
  logic [1:0] err;

  typedef struct packed { logic vld; logic [7:0] ptr; } exp_t;
  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   mstk[4][$];
  int   mrr = 0;
  int   expc;

  always #5 clk = ~clk;

  stk_pipe_al_mp dut (
    .clk(clk), .arst_n(arst_n), .i_ad_alloc(alloc),
    .o_ad_busy_r(busy), .o_ad_empty_r(empty), .o_ad_low_r(low),
    .o_lk_vld_r(lk_vld), .o_lk_ptr_w(lk_ptr),
    .i_dealloc_vld(dvld), .i_dealloc_ptr(dptr), .o_dealloc_rdy(rdy),
    .o_free_cnt_r(free_cnt), .o_err_r(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic a, input logic v0, input logic [7:0] p0,
                     input logic v1, input logic [7:0] p1);
    alloc = a;
    dvld  = {v1, v0};
    dptr  = {p1, p0};
  endtask

  task automatic exp_lk(input logic v, input logic [7:0] p);
    sb.push_back({v, p});
  endtask

  // Advance one clock, then settle the scoreboard entry for the alloc that edge captured.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("lk_vld", 32'(lk_vld), 32'(e.vld));
      if (e.vld) chk("lk_ptr", 32'(lk_ptr), 32'(e.ptr));
    end else begin
      chk("lk_vld_idle", 32'(lk_vld), 32'd0);
    end
  endtask

  function automatic int m_pop();
    int b;
    for (int i = 0; i < 4; i++) begin
      b = (mrr + i) % 4;
      if (mstk[b].size() > 0) begin
        mrr = (b + 1) % 4;
        return (b << 6) | mstk[b].pop_back();
      end
    end
    return -1;
  endfunction

  function automatic void m_push(input int p);
    mstk[p >> 6].push_back(p & 63);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    arst_n = 1'b1;
    drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    #1 arst_n = 1'b0;
    dvld = 2'b11;
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_low", 32'(low), 32'd1);
    chk("rst_lk_vld", 32'(lk_vld), 32'd0);
    chk("rst_lk_ptr", 32'(lk_ptr), 32'd0);
    chk("rst_free", 32'(free_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    dvld = 2'b00;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;

    // Init: 64 cycles. Allocs and returns are ignored throughout.
    for (int i = 0; i < 64; i++) begin
      chk("init_busy", 32'(busy), 32'd1);
      chk("init_free", 32'(free_cnt), 32'(4*i));
      if (i == 10) begin
        drv(1'b1, 1'b1, 8'h05, 1'b1, 8'h45);
        #1 chk("init_rdy", 32'(rdy), 32'd0);
      end else begin
        drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      end
      cyc();
    end
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_free", 32'(free_cnt), 32'd256);
    chk("run_empty", 32'(empty), 32'd0);
    chk("run_low", 32'(low), 32'd0);
    chk("run_err", 32'(err), 32'd0);
    for (int b = 0; b < 4; b++)
      for (int l = 63; l >= 0; l--) mstk[b].push_back(l);

    // Four allocs in a row take the top of each bank in round-robin order.
    drv(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int b = 0; b < 4; b++) begin
      exp_lk(1'b1, 8'(b << 6));
      void'(m_pop());
      cyc();
    end
    chk("rr4_free", 32'(free_cnt), 32'd252);

    // Alloc with two returns: port0 is bypassed and port1 is pushed to bank1.
    drv(1'b1, 1'b1, 8'h85, 1'b1, 8'h47);
    #1 chk("byp_rdy", 32'(rdy), 32'd3);
    exp_lk(1'b1, 8'h85);
    m_push(8'h47);
    cyc();
    chk("byp_free", 32'(free_cnt), 32'd253);
    drv(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int n = 0; n < 4; n++) begin
      exp_lk(1'b1, 8'(m_pop()));
      cyc();
    end
    chk("pop_free", 32'(free_cnt), 32'd249);

    // Both ports target bank3: port1 waits one cycle.
    drv(1'b0, 1'b1, 8'hC0, 1'b1, 8'hC1);
    #1 chk("conf_rdy", 32'(rdy), 32'd1);
    m_push(8'hC0);
    cyc();
    drv(1'b0, 1'b0, 8'h00, 1'b1, 8'hC1);
    #1 chk("conf_rdy2", 32'(rdy), 32'd3);
    m_push(8'hC1);
    cyc();
    drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("conf_free", 32'(free_cnt), 32'd251);
    chk("conf_err", 32'(err), 32'd0);

    // Drain the whole pool and check the flags on every step.
    expc = 251;
    drv(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    while (expc > 0) begin
      exp_lk(1'b1, 8'(m_pop()));
      cyc();
      expc--;
      chk("drain_free", 32'(free_cnt), 32'(expc));
      chk("drain_low", 32'(low), (expc <= 4) ? 32'd1 : 32'd0);
      chk("drain_empty", 32'(empty), (expc == 0) ? 32'd1 : 32'd0);
    end
    exp_lk(1'b0, 8'h00);
    cyc();
    chk("udf_err", 32'(err), 32'd1);
    chk("udf_free", 32'(free_cnt), 32'd0);
    drv(1'b1, 1'b1, 8'h05, 1'b0, 8'h00);
    exp_lk(1'b1, 8'h05);
    cyc();
    chk("empty_byp_free", 32'(free_cnt), 32'd0);
    chk("empty_byp_empty", 32'(empty), 32'd1);
    drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Reset while running, then reset again in the middle of init.
    arst_n = 1'b0;
    #1;
    chk("rst2_free", 32'(free_cnt), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd1);
    chk("rst2_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (30) cyc();
    chk("mid_free", 32'(free_cnt), 32'd120);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_free", 32'(free_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 arst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("reinit_busy", 32'(busy), 32'd1);
      cyc();
    end
    chk("reinit_busy_done", 32'(busy), 32'd0);
    chk("reinit_free", 32'(free_cnt), 32'd256);

    // A push to a full bank is dropped and reported.
    drv(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    #1 chk("ovf_rdy", 32'(rdy[0]), 32'd1);
    cyc();
    drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("ovf_err", 32'(err), 32'd2);
    chk("ovf_free", 32'(free_cnt), 32'd256);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
